// File: rtl/lif_neuron.sv
// -----------------------------------------------------------------------------
// lif_neuron
//
// Leaky integrate-and-fire neuron with a signed weighted dendrite, shift-based
// leak, threshold firing and a refractory period. One inference window covers
// TS time-step strobes. At the end of the window a single AXI-Stream beat
// reports the spike count and the index of the first spike.
//
// Parameters
//   S           number of synapse inputs
//   WW          signed weight width
//   VW          signed membrane-potential width
//   V_TH        firing threshold (signed, fits VW)
//   V_RESET     membrane value after a spike
//   LEAK_SHIFT  leak per step = V >>> LEAK_SHIFT
//   RP          refractory length in time steps (0 = none)
//   TS          time steps per inference window
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   start        pulse; begins a window (accepted in IDLE only)
//   time_step    single-cycle time-step strobe (acted on in RUN only)
//   spike_in     per-synapse presynaptic spikes, sampled on time_step
//   weight       packed signed weights, weight[j*WW +: WW] is synapse j
//   force_spike  fire on this time step regardless of threshold/refractory
//   spike        registered fire flag for the most recent time step
//   membrane     current membrane potential (signed)
//   busy         high in RUN and REPORT
//   m_tvalid     report valid
//   m_tready     report accepted
//   m_tdata      spike count of the window
//   m_tuser      first-spike step index, TS if the window had no spike
//   m_tlast      constant 1 (single-beat report)
// -----------------------------------------------------------------------------
module lif_neuron #(
    parameter  int S          = 8,
    parameter  int WW         = 8,
    parameter  int VW         = 16,
    parameter  int V_TH       = 64,
    parameter  int V_RESET    = 0,
    parameter  int LEAK_SHIFT = 4,
    parameter  int RP         = 2,
    parameter  int TS         = 16,
    localparam int TSW        = $clog2(TS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 time_step,
    input  logic [S-1:0]         spike_in,
    input  logic [S*WW-1:0]      weight,
    input  logic                 force_spike,
    output logic                 spike,
    output logic signed [VW-1:0] membrane,
    output logic                 busy,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [TSW-1:0]       m_tdata,
    output logic [TSW-1:0]       m_tuser,
    output logic                 m_tlast
);

    // Synaptic sum width: one extra bit per doubling of S plus a guard bit,
    // so the sum of S weights can never overflow.
    localparam int SUMW = WW + $clog2(S) + 1;
    // Working width for the membrane update: wide enough for the unsaturated
    // V - leak + sum of either operand width.
    localparam int FW   = ((VW > SUMW) ? VW : SUMW) + 2;
    // Refractory counter width; keep one bit even when RP = 0.
    localparam int RPW  = (RP > 0) ? $clog2(RP + 1) : 1;

    localparam logic signed [FW-1:0] V_MAX_F = {{(FW-VW+1){1'b0}}, {(VW-1){1'b1}}};
    localparam logic signed [FW-1:0] V_MIN_F = {{(FW-VW+1){1'b1}}, {(VW-1){1'b0}}};
    localparam logic signed [VW-1:0] V_TH_V    = VW'(V_TH);
    localparam logic signed [VW-1:0] V_RESET_V = VW'(V_RESET);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_REPORT
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                 state_q,    state_d;
    logic signed [VW-1:0]   membrane_q, membrane_d;
    logic                   spike_q,    spike_d;
    logic [TSW-1:0]         step_q,     step_d;
    logic [TSW-1:0]         count_q,    count_d;
    logic [TSW-1:0]         first_q,    first_d;
    logic [RPW-1:0]         ref_q,      ref_d;

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    logic signed [WW-1:0]   w_arr [S];
    logic signed [SUMW-1:0] syn_sum;
    logic signed [VW-1:0]   leak_v;
    logic signed [FW-1:0]   v_cur_f;
    logic signed [FW-1:0]   leak_f;
    logic signed [FW-1:0]   sum_f;
    logic signed [FW-1:0]   sum_gated_f;
    logic signed [FW-1:0]   v_full;
    logic signed [VW-1:0]   v_sat;
    logic                   refractory;
    logic                   fire;
    logic                   last_step;

    // Signed sum of the weights of all active synapses.
    // NOTE: combinational blocks assign every output a default before any
    // conditional logic, so no path can leave a value held and infer a latch.
    always_comb begin
        syn_sum = '0;
        for (int j = 0; j < S; j++) begin
            w_arr[j] = weight[j*WW +: WW];
            if (spike_in[j]) begin
                syn_sum = syn_sum + $signed({{(SUMW-WW){w_arr[j][WW-1]}}, w_arr[j]});
            end
        end
    end

    assign refractory  = (ref_q != '0);
    assign leak_v      = membrane_q >>> LEAK_SHIFT;
    assign v_cur_f     = {{(FW-VW){membrane_q[VW-1]}}, membrane_q};
    assign leak_f      = {{(FW-VW){leak_v[VW-1]}}, leak_v};
    assign sum_f       = {{(FW-SUMW){syn_sum[SUMW-1]}}, syn_sum};
    // Input is blanked while refractory; the leak still applies.
    assign sum_gated_f = refractory ? '0 : sum_f;
    assign v_full      = v_cur_f - leak_f + sum_gated_f;

    // Clamp to the VW signed range instead of wrapping.
    always_comb begin
        if (v_full > V_MAX_F) begin
            v_sat = {1'b0, {(VW-1){1'b1}}};
        end else if (v_full < V_MIN_F) begin
            v_sat = {1'b1, {(VW-1){1'b0}}};
        end else begin
            v_sat = v_full[VW-1:0];
        end
    end

    assign fire      = force_spike | (~refractory & (v_sat >= V_TH_V));
    assign last_step = (step_q == TSW'(TS - 1));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        membrane_d = membrane_q;
        spike_d    = spike_q;
        step_d     = step_q;
        count_d    = count_q;
        first_d    = first_q;
        ref_d      = ref_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    membrane_d = '0;
                    spike_d    = 1'b0;
                    step_d     = '0;
                    count_d    = '0;
                    first_d    = TSW'(TS);
                    // A new window never inherits refractory time.
                    ref_d      = '0;
                end
            end

            ST_RUN: begin
                if (time_step) begin
                    if (fire) begin
                        membrane_d = V_RESET_V;
                        spike_d    = 1'b1;
                        ref_d      = RPW'(RP);
                        if (count_q != {TSW{1'b1}}) begin
                            count_d = count_q + TSW'(1);
                        end
                        // first_q still holds TS until the first fire.
                        if (first_q == TSW'(TS)) begin
                            first_d = step_q;
                        end
                    end else begin
                        membrane_d = v_sat;
                        spike_d    = 1'b0;
                        if (refractory) begin
                            ref_d = ref_q - RPW'(1);
                        end
                    end
                    step_d = step_q + TSW'(1);
                    if (last_step) begin
                        state_d = ST_REPORT;
                        // The fire flag is not carried into REPORT.
                        spike_d = 1'b0;
                    end
                end
            end

            ST_REPORT: begin
                if (m_tready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            membrane_q <= '0;
            spike_q    <= 1'b0;
            step_q     <= '0;
            count_q    <= '0;
            first_q    <= TSW'(TS);
            ref_q      <= '0;
        end else begin
            state_q    <= state_d;
            membrane_q <= membrane_d;
            spike_q    <= spike_d;
            step_q     <= step_d;
            count_q    <= count_d;
            first_q    <= first_d;
            ref_q      <= ref_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from registers; the report fields cannot change
    // while in REPORT because nothing updates them there)
    // -------------------------------------------------------------------------
    assign spike    = spike_q;
    assign membrane = membrane_q;
    assign busy     = (state_q != ST_IDLE);
    assign m_tvalid = (state_q == ST_REPORT);
    assign m_tdata  = count_q;
    assign m_tuser  = first_q;
    assign m_tlast  = 1'b1;

endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Parametrised leaky integrate-and-fire neuron; successor to the single-spike OR-dendrite neuron.
- Accumulates signed per-synapse weights into a membrane potential once per time step, applies shift-based leak, fires on threshold, and enforces a refractory period.
- Runs one inference window of TS time steps, then emits one AXI-Stream report beat: spike count and first-spike time.
- Sits in the SNN layer fabric between the synapse array and the result collector.

Parameters:
- S, 8, number of synapse inputs.
- WW, 8, signed weight width.
- VW, 16, signed membrane-potential width.
- V_TH, 64, firing threshold (signed, fits VW).
- V_RESET, 0, membrane value after a spike.
- LEAK_SHIFT, 4, leak per step = V >>> LEAK_SHIFT (arithmetic shift).
- RP, 2, refractory length in time steps (0 = none).
- TS, 16, time steps per inference window; TSW = $clog2(TS+1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins an inference window (accepted in IDLE only).
- time_step  in  1  single-cycle time-step strobe.
- spike_in  in  S  per-synapse presynaptic spike, sampled on time_step.
- weight  in  S*WW  packed signed weights; weight[j*WW +: WW] belongs to synapse j.
- force_spike  in  1  forces a fire on this time step, ignoring threshold and refractory.
- spike  out  1  registered fire flag for the most recent time step.
- membrane  out  VW  current membrane potential (signed).
- busy  out  1  high in RUN and REPORT.
- m_tvalid  out  1  report valid.
- m_tready  in  1  report accepted.
- m_tdata  out  TSW  spike count for the window.
- m_tuser  out  TSW  index of the first spike (0..TS-1); TS if no spike occurred.
- m_tlast  out  1  constant 1.

Behaviour:
- Reset: state IDLE; spike, membrane, m_tvalid, busy, counters, refractory counter = 0; first-spike register = TS.
- States:
  - IDLE -> RUN on start. Entering RUN clears membrane, step counter, spike count and spike, and sets first-spike register = TS.
  - RUN -> REPORT after TS time_step strobes.
  - REPORT -> IDLE on the m_tvalid & m_tready cycle.
- start is ignored in RUN and REPORT. time_step is ignored in IDLE and REPORT.
- On each time_step in RUN:
  - sum = signed sum of weight[j] over j with spike_in[j] = 1; width WW + $clog2(S) + 1 (no overflow).
  - refractory = (ref_cnt != 0).
  - v_next = V - (V >>> LEAK_SHIFT) + (refractory ? 0 : sum), computed at full width, then saturated to the VW signed range.
  - fire = force_spike | (~refractory & v_next >= V_TH).
  - If fire:
    - membrane <= V_RESET; spike <= 1; ref_cnt <= RP.
    - spike_count++ (saturates at 2^TSW - 1).
    - If this is the first spike, first-spike register <= current step index.
  - Else: membrane <= v_next; spike <= 0; if refractory, ref_cnt decrements.
  - Step counter increments. On the TS-th strobe the next state is REPORT.
- Latency: spike and membrane update on the cycle after the time_step strobe.
- REPORT:
  - m_tvalid = 1; m_tdata, m_tuser and m_tlast hold stable until the handshake.
  - spike is cleared on entry to REPORT.
- Simultaneous events:
  - force_spike during refractory fires and reloads ref_cnt = RP.
  - force_spike with no time_step has no effect.
- Reset mid-operation: returns to IDLE immediately; a pending report is dropped.

Test Plan:
(Parameters for all scenarios: S=4, WW=8, VW=16, V_TH=64, V_RESET=0, LEAK_SHIFT=4, RP=2, TS=8, unless stated otherwise.)
1. Refractory pacing: all weights 20, spike_in=4'b1111 on every step, m_tready=1 -> spikes on steps 0, 3, 6; report tdata=3, tuser=0, tlast=1.
2. Leak: weight0=40, spike_in=4'b0001 on step 0 only -> membrane 40, 38, 36, ...; no spike; report tdata=0, tuser=8.
3. Summation: weights {30, 40, 0, 0}, spike_in=4'b0011 on step 2 only -> spike on step 2; report tdata=1, tuser=2.
4. Saturation (VW=10): all weights -128, all inputs active -> membrane -512 after step 0, stays at -512 after step 1 (no wrap); no spike.
5. Force and backpressure:
   - force_spike on steps 1 and 2 -> both fire; spike count 2.
   - Hold m_tready=0 for 5 cycles -> m_tvalid stays high with stable tdata=2, tuser=1.
   - start pulse during REPORT is ignored; accepted after the handshake.
6. Reset mid-RUN after step 3 -> next cycle: busy=0, spike=0, membrane=0, no report; a new start runs a clean window.
